keyword_port_arbiter: RTL and testbench
=======================================

KEYWORD_PORT_ARBITER -- requirements
Module: keyword_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_REQ, 4, number of requesters; power of two, range 2..8.
- DATA_W, 8, data width per requester.
- IDX_W, $clog2(NUM_REQ), requester index width.
REQ-002 Ports (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- input_valid, input, NUM_REQ, per-requester request; bit i belongs to requester i.
- input_data, input, NUM_REQ*DATA_W, packed data; requester i uses [i*DATA_W +: DATA_W].
- input_ready, output, NUM_REQ, registered one-hot accept pulse.
- output_data, output, DATA_W, registered captured data.
- output_valid, output, 1, output_data is valid.
- output_ready, input, 1, downstream accept.
- output_source, output, IDX_W, index of the requester whose data is on output_data.
- grant_count, output, 16, completed-transfer counter.
- busy, output, 1, high whenever the state is not IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, LOAD, SEND, encoded in 2 bits; the encoding 2'b11 SHALL return to IDLE.
REQ-004 IDLE: if input_valid is non-zero, the arbiter SHALL select the first requester with input_valid set, searching circularly from rr_ptr upward, latch it as grant index g, and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-005 LOAD: input_ready[g] SHALL be 1 for exactly this one cycle; all other input_ready bits SHALL be 0.
REQ-006 LOAD transfer: if input_valid[g]=1, the block SHALL capture input_data[g] into output_data, set output_source=g, and go to SEND.
REQ-007 LOAD withdrawal: if input_valid[g]=0, no transfer SHALL occur; the block SHALL return to IDLE with rr_ptr, output_data and grant_count unchanged.
REQ-008 SEND: output_valid SHALL be 1, with output_data and output_source held stable.
REQ-009 SEND completion: on output_ready=1 the block SHALL go to IDLE, set rr_ptr=(g+1) mod NUM_REQ, and increment grant_count, which wraps 0xFFFF->0x0000.
REQ-010 output_ready SHALL be ignored in IDLE and LOAD.
REQ-011 output_valid SHALL be 0 in every state except SEND.
REQ-012 Latency: input_valid seen in IDLE at cycle N gives input_ready at N+1 and output_valid at N+2.
REQ-013 Throughput: with output_ready held high, a back-to-back transfer completes every 3 cycles.
REQ-014 Changes to input_valid or input_data of non-granted requesters during LOAD or SEND SHALL have no effect.
REQ-015 With all requesters continuously valid, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 foreign transfers.
REQ-016 A requester SHALL hold input_valid and its data stable until it sees input_ready; the block SHALL NOT check data stability.

Reset
REQ-017 With reset=1 at a rising edge, the block SHALL set state=IDLE, rr_ptr=0, and set input_ready, output_data, output_valid, output_source, grant_count and busy to 0.
REQ-018 Reset SHALL take priority over every other event, including reset asserted in LOAD or SEND; an in-flight transfer is dropped and not counted.
REQ-019 In the first cycle after reset deasserts, the block SHALL behave as IDLE with rr_ptr=0.

Verification
REQ-020 Single request: input_valid=4'b0100, data2=8'hA5, output_ready=1 -> input_ready=4'b0100 one cycle later; output_valid=1, output_data=8'hA5, output_source=2 two cycles later; grant_count=1.
REQ-021 Round robin: all four valid, data_i=8'h10+i, output_ready=1 for 12 cycles -> output_source sequence 0,1,2,3; grant_count=4; each input_ready pulse is one cycle wide.
REQ-022 Backpressure: output_ready=0 for 5 cycles in SEND -> output_valid, output_data and output_source stay constant; busy=1; output_ready=1 completes the transfer; grant_count increments once.
REQ-023 Withdrawal: requester 1 drops input_valid in the LOAD cycle -> no output_valid; next grant searches again from rr_ptr=0; grant_count unchanged.
REQ-024 Reset mid-SEND: reset=1 while output_valid=1 with grant_count=3 -> next cycle all outputs are 0, grant_count=0, and the next request from requester 3 with all valid is granted to requester 0 first.
REQ-025 Wrap: preload grant_count to 0xFFFF by forcing or by a long run, then complete one transfer -> grant_count=0x0000.

Source files
------------

// File: rtl/keyword_port_arbiter.sv
// keyword_port_arbiter: round-robin N-to-1 arbiter with a three-state
// IDLE/LOAD/SEND handshake. A requester is picked in IDLE and offered a
// one-cycle accept pulse in LOAD. If it is still valid, its data is captured
// and presented downstream in SEND until the downstream side accepts it.
module keyword_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        input_valid,
  input  logic [NUM_REQ*DATA_W-1:0] input_data,
  output logic [NUM_REQ-1:0]        input_ready,
  output logic [DATA_W-1:0]         output_data,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [IDX_W-1:0]          output_source,
  output logic [15:0]               grant_count,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_SEND = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    w_grant_next;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    w_rr_next;
  logic [DATA_W-1:0]   r_output_data;
  logic [DATA_W-1:0]   w_data_next;
  logic [IDX_W-1:0]    r_output_source;
  logic [IDX_W-1:0]    w_src_next;
  logic [15:0]         r_grant_count;
  logic [15:0]         w_count_next;
  logic [NUM_REQ-1:0]  r_input_ready;
  logic [NUM_REQ-1:0]  w_ready_next;
  logic                r_output_valid;
  logic                w_ovalid_next;
  logic                r_busy;
  logic                w_busy_next;

  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic [DATA_W-1:0]   w_data_slice [NUM_REQ];

  // Unpack the flat data bus into one slice per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_data_slice[gi] = input_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Circular priority search starting at rr_ptr; scanning offsets from the
  // far end down lets the smallest offset overwrite and win. The index add
  // wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    w_pick_idx = r_rr_ptr;
    w_pick_any = |input_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (input_valid[r_rr_ptr + IDX_W'(k)]) begin
        w_pick_idx = r_rr_ptr + IDX_W'(k);
      end
    end
  end

  // Next-state and next-output logic. Every output is a flop, so its next
  // value is decoded from the next state rather than the current one.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_rr_next    = r_rr_ptr;
    w_data_next  = r_output_data;
    w_src_next   = r_output_source;
    w_count_next = r_grant_count;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_next = w_pick_idx;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A requester that dropped valid during its accept cycle forfeits
        // the slot; pointer and counter stay put so the search repeats.
        if (input_valid[r_grant]) begin
          w_data_next  = w_data_slice[r_grant];
          w_src_next   = r_grant;
          w_state_next = ST_SEND;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (output_ready) begin
          w_state_next = ST_IDLE;
          w_rr_next    = r_grant + IDX_W'(1);
          w_count_next = r_grant_count + 16'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_ready_next  = (w_state_next == ST_LOAD)
                    ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_next)
                    : '0;
    w_ovalid_next = (w_state_next == ST_SEND);
    w_busy_next   = (w_state_next != ST_IDLE);
  end

  // State and output registers; reset wins over everything, dropping any
  // in-flight transfer without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_grant         <= '0;
      r_rr_ptr        <= '0;
      r_output_data   <= '0;
      r_output_source <= '0;
      r_grant_count   <= '0;
      r_input_ready   <= '0;
      r_output_valid  <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_grant         <= w_grant_next;
      r_rr_ptr        <= w_rr_next;
      r_output_data   <= w_data_next;
      r_output_source <= w_src_next;
      r_grant_count   <= w_count_next;
      r_input_ready   <= w_ready_next;
      r_output_valid  <= w_ovalid_next;
      r_busy          <= w_busy_next;
    end
  end

  assign input_ready   = r_input_ready;
  assign output_data   = r_output_data;
  assign output_valid  = r_output_valid;
  assign output_source = r_output_source;
  assign grant_count   = r_grant_count;
  assign busy          = r_busy;

endmodule

// File: tb/tb_keyword_port_arbiter.sv
// Testbench for keyword_port_arbiter: per-cycle vector table plus hand-written
// sequences for backpressure, non-granted input changes and counter wrap.
module tb_keyword_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  input_valid;
  logic [31:0] input_data;
  logic [3:0]  input_ready;
  logic [7:0]  output_data;
  logic        output_valid;
  logic        output_ready;
  logic [1:0]  output_source;
  logic [15:0] grant_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  keyword_port_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_data   (input_data),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_source(output_source),
    .grant_count  (grant_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  er;
    logic        eov;
    logic [7:0]  ed;
    logic [1:0]  es;
    logic [15:0] ec;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] v,
                              input logic [31:0] d, input logic ordy,
                              input logic [3:0] er, input logic eov,
                              input logic [7:0] ed, input logic [1:0] es,
                              input logic [15:0] ec, input logic eb);
    vec_t t;
    t = '{rst, v, d, ordy, er, eov, ed, es, ec, eb};
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [3:0] er, input logic eov,
                            input logic [7:0] ed, input logic [1:0] es,
                            input logic [15:0] ec, input logic eb);
    chk({tag, ".input_ready"},   32'(input_ready),   32'(er));
    chk({tag, ".output_valid"},  32'(output_valid),  32'(eov));
    chk({tag, ".output_data"},   32'(output_data),   32'(ed));
    chk({tag, ".output_source"}, 32'(output_source), 32'(es));
    chk({tag, ".grant_count"},   32'(grant_count),   32'(ec));
    chk({tag, ".busy"},          32'(busy),          32'(eb));
    $display("%s: rdy=%b ov=%b data=%h src=%0d cnt=%0d busy=%b",
             tag, input_ready, output_valid, output_data, output_source, grant_count, busy);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DA = 32'h00A5_0000;
  localparam logic [31:0] DR = 32'h1312_1110;
  localparam logic [31:0] W1 = 32'h0000_5500;
  localparam logic [31:0] W2 = 32'h7700_5500;

  initial begin
    reset        = 1'b1;
    input_valid  = '0;
    input_data   = '0;
    output_ready = 1'b0;

    // Single request to requester 2
    add(0, 4'b0100, DA, 1, 4'b0100, 0, 8'h00, 2'd0, 16'd0, 1);
    add(0, 4'b0100, DA, 1, 4'b0000, 1, 8'hA5, 2'd2, 16'd0, 1);
    add(0, 4'b0000, DA, 1, 4'b0000, 0, 8'hA5, 2'd2, 16'd1, 0);
    // Reset, then round robin with all four valid
    add(1, 4'b0000, DR, 1, 4'b0000, 0, 8'h00, 2'd0, 16'd0, 0);
    add(0, 4'b1111, DR, 1, 4'b0001, 0, 8'h00, 2'd0, 16'd0, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 1, 8'h10, 2'd0, 16'd0, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 0, 8'h10, 2'd0, 16'd1, 0);
    add(0, 4'b1111, DR, 1, 4'b0010, 0, 8'h10, 2'd0, 16'd1, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 1, 8'h11, 2'd1, 16'd1, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 0, 8'h11, 2'd1, 16'd2, 0);
    add(0, 4'b1111, DR, 1, 4'b0100, 0, 8'h11, 2'd1, 16'd2, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 1, 8'h12, 2'd2, 16'd2, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 0, 8'h12, 2'd2, 16'd3, 0);
    add(0, 4'b1111, DR, 1, 4'b1000, 0, 8'h12, 2'd2, 16'd3, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 1, 8'h13, 2'd3, 16'd3, 1);
    // Reset mid-SEND with count 3, then restart grants at requester 0
    add(1, 4'b1111, DR, 1, 4'b0000, 0, 8'h00, 2'd0, 16'd0, 0);
    add(0, 4'b1111, DR, 1, 4'b0001, 0, 8'h00, 2'd0, 16'd0, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 1, 8'h10, 2'd0, 16'd0, 1);
    add(0, 4'b1111, DR, 1, 4'b0000, 0, 8'h10, 2'd0, 16'd1, 0);
    // Withdrawal of requester 1 during LOAD, then search again from 0
    add(1, 4'b0000, W1, 1, 4'b0000, 0, 8'h00, 2'd0, 16'd0, 0);
    add(0, 4'b0010, W1, 1, 4'b0010, 0, 8'h00, 2'd0, 16'd0, 1);
    add(0, 4'b0000, W1, 1, 4'b0000, 0, 8'h00, 2'd0, 16'd0, 0);
    add(0, 4'b1010, W2, 1, 4'b0010, 0, 8'h00, 2'd0, 16'd0, 1);
    add(0, 4'b1010, W2, 1, 4'b0000, 1, 8'h55, 2'd1, 16'd0, 1);
    add(0, 4'b1000, W2, 1, 4'b0000, 0, 8'h55, 2'd1, 16'd1, 0);
    add(0, 4'b1000, W2, 1, 4'b1000, 0, 8'h55, 2'd1, 16'd1, 1);
    add(0, 4'b1000, W2, 1, 4'b0000, 1, 8'h77, 2'd3, 16'd1, 1);
    add(0, 4'b0000, W2, 1, 4'b0000, 0, 8'h77, 2'd3, 16'd2, 0);

    // Reset state
    step();
    step();
    expect_all("reset", 4'b0000, 0, 8'h00, 2'd0, 16'd0, 0);

    // Table-driven per-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      reset        = vecs[i].rst;
      input_valid  = vecs[i].v;
      input_data   = vecs[i].d;
      output_ready = vecs[i].ordy;
      step();
      expect_all($sformatf("vec%0d", i), vecs[i].er, vecs[i].eov, vecs[i].ed,
                 vecs[i].es, vecs[i].ec, vecs[i].eb);
    end

    // Backpressure: output held for 5 cycles while others churn
    reset = 1'b1; input_valid = '0; output_ready = 1'b0;
    step();
    reset = 1'b0; input_valid = 4'b0100; input_data = 32'h003C_0000;
    step();
    expect_all("bp_load", 4'b0100, 0, 8'h00, 2'd0, 16'd0, 1);
    step();
    expect_all("bp_send", 4'b0000, 1, 8'h3C, 2'd2, 16'd0, 1);
    for (int i = 0; i < 5; i++) begin
      input_valid = (i % 2 == 0) ? 4'b1011 : 4'b1111;
      input_data  = 32'h1122_3344 + 32'(i) * 32'h0101_0101;
      step();
      expect_all($sformatf("bp_hold%0d", i), 4'b0000, 1, 8'h3C, 2'd2, 16'd0, 1);
    end
    input_valid = '0; output_ready = 1'b1;
    step();
    expect_all("bp_done", 4'b0000, 0, 8'h3C, 2'd2, 16'd1, 0);
    step();
    expect_all("bp_idle", 4'b0000, 0, 8'h3C, 2'd2, 16'd1, 0);

    // Counter wrap: preload 0xFFFF and complete one transfer
    force dut.r_grant_count = 16'hFFFF;
    #1;
    release dut.r_grant_count;
    chk("wrap_preload", 32'(grant_count), 32'h0000_FFFF);
    input_valid = 4'b0001; input_data = 32'h0000_005A;
    step();
    expect_all("wrap_load", 4'b0001, 0, 8'h3C, 2'd2, 16'hFFFF, 1);
    step();
    expect_all("wrap_send", 4'b0000, 1, 8'h5A, 2'd0, 16'hFFFF, 1);
    input_valid = '0;
    step();
    expect_all("wrap_done", 4'b0000, 0, 8'h5A, 2'd0, 16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
